// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: WIDTH-bit carry chain cut into STAGES slices, valid/ready on both sides.
// Define PIPE_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipe_adder #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef PIPE_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             c_out
);

   localparam int S    = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   // Per-stage registers: operands (b already conditioned), partial sum, slice carry, valid.
   logic [STAGES-1:0] r_valid;
   logic [STAGES-1:0] r_carry;
   logic [WIDTH-1:0]  r_a   [0:STAGES-1];
   logic [WIDTH-1:0]  r_b   [0:STAGES-1];
   logic [WIDTH-1:0]  r_sum [0:STAGES-1];

   logic [WIDTH-1:0]  w_src_a   [0:STAGES-1];
   logic [WIDTH-1:0]  w_src_b   [0:STAGES-1];
   logic [WIDTH-1:0]  w_src_sum [0:STAGES-1];
   logic [WIDTH-1:0]  w_new_sum [0:STAGES-1];
   logic [S:0]        w_slice   [0:STAGES-1];
   logic [STAGES-1:0] w_src_c;
   logic [STAGES-1:0] w_src_valid;
   logic [STAGES:0]   w_rdy;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({S{1'b1}}) << (gi * S);

         if (gi == 0) begin : g_head
            assign w_src_a[gi]     = a;
            assign w_src_b[gi]     = sub ? ~b : b;
            assign w_src_c[gi]     = c_in;
            assign w_src_sum[gi]   = '0;
            assign w_src_valid[gi] = in_valid;
         end else begin : g_body
            assign w_src_a[gi]     = r_a[gi-1];
            assign w_src_b[gi]     = r_b[gi-1];
            assign w_src_c[gi]     = r_carry[gi-1];
            assign w_src_sum[gi]   = r_sum[gi-1];
            assign w_src_valid[gi] = r_valid[gi-1];
         end

         assign w_slice[gi] = {1'b0, w_src_a[gi][gi*S +: S]}
                            + {1'b0, w_src_b[gi][gi*S +: S]}
                            + (S+1)'(w_src_c[gi]);

         assign w_new_sum[gi] = (w_src_sum[gi] & ~SLICE_MASK)
                              | (WIDTH'(w_slice[gi][S-1:0]) << (gi * S));
      end
   endgenerate

   // w_rdy[k]: stage k may load this cycle (empty, or its contents move on).
   always_comb begin
      logic v_rdy;
      v_rdy          = out_ready;
      w_rdy          = '0;
      w_rdy[STAGES]  = out_ready;
      for (int k = LAST; k >= 0; k--) begin
         v_rdy    = !r_valid[k] || v_rdy;
         w_rdy[k] = v_rdy;
      end
   end

`ifdef PIPE_ADDER_OVF_EN
   logic r_ovf;
   logic w_ovf;

   assign w_ovf = (w_src_a[LAST][WIDTH-1] == w_src_b[LAST][WIDTH-1])
               && (w_new_sum[LAST][WIDTH-1] != w_src_a[LAST][WIDTH-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_rdy[LAST] && w_src_valid[LAST]) begin
         r_ovf <= w_ovf;
      end
   end

   assign ovf = r_ovf;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_carry <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_rdy[k]) begin
               r_valid[k] <= w_src_valid[k];
               // Data only moves with a real transaction; bubbles leave it untouched.
               if (w_src_valid[k]) begin
                  r_a[k]     <= w_src_a[k];
                  r_b[k]     <= w_src_b[k];
                  r_sum[k]   <= w_new_sum[k];
                  r_carry[k] <= w_slice[k][S];
               end
            end
         end
      end
   end

   assign in_ready  = w_rdy[0];
   assign out_valid = r_valid[LAST];
   assign sum       = r_sum[LAST];
   assign c_out     = r_carry[LAST];

endmodule
